// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target: serves READ, JEDEC ID, READ STATUS and DEVICE ID from a byte-wide memory port.
// All SPI pins are retimed into io_mainClk, so SCLK must stay at or below io_mainClk/8.
module spi_flash_responder #(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018,
    parameter logic [7:0]  DEVICE_ID  = 8'h17
) (
    input  logic                  io_mainClk,
    input  logic                  io_asyncReset,
    input  logic                  io_spi_sclk,
    input  logic                  io_spi_cs_n,
    input  logic                  io_spi_mosi,
    output logic                  io_spi_miso,
    output logic                  io_mem_cmd_valid,
    output logic [ADDR_WIDTH-1:0] io_mem_cmd_address,
    input  logic [7:0]            io_mem_rsp_data,
    output logic                  io_selected,
    output logic [7:0]            io_lastCommand
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_STATUS, S_DUMMY, S_IGNORE
    } state_t;

    state_t state_reg, state_next;

    logic sclk_meta_reg, sclk_sync_reg, sclk_prev_reg;
    logic cs_meta_reg, cs_sync_reg, cs_prev_reg;
    logic mosi_meta_reg, mosi_sync_reg;

    logic [2:0]            bit_cnt_reg;
    logic [7:0]            rx_reg;
    logic [7:0]            tx_reg;
    logic [7:0]            hold_reg;
    logic [ADDR_WIDTH-1:0] addr_acc_reg;
    logic [1:0]            addr_bytes_reg;
    logic [1:0]            id_idx_reg;
    logic [1:0]            dummy_cnt_reg;
    logic                  rsp_pending_reg;

    logic                  link_active;
    logic                  rise;
    logic                  fall;
    logic                  cs_fall;
    logic                  byte_done;
    logic                  mem_issue;
    logic [7:0]            rx_next;
    logic [7:0]            load_byte;
    logic [ADDR_WIDTH-1:0] addr_acc_next;

    // cs_n high masks every sclk edge, so a simultaneous cs rise always wins.
    assign link_active   = ~cs_sync_reg && (state_reg != S_IDLE);
    assign rise          = sclk_sync_reg & ~sclk_prev_reg & link_active;
    assign fall          = ~sclk_sync_reg & sclk_prev_reg & link_active;
    assign cs_fall       = cs_prev_reg & ~cs_sync_reg;
    assign byte_done     = rise && (bit_cnt_reg == 3'd7);
    assign rx_next       = {rx_reg[6:0], mosi_sync_reg};
    assign addr_acc_next = {addr_acc_reg[ADDR_WIDTH-2:0], mosi_sync_reg};

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_issue  = 1'b0;
        if (state_reg != S_IDLE && cs_sync_reg) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (cs_fall) state_next = S_CMD;
                end
                S_CMD: begin
                    if (byte_done) begin
                        case (rx_next)
                            8'h03:   state_next = S_ADDR;
                            8'h9F:   state_next = S_ID;
                            8'h05:   state_next = S_STATUS;
                            8'hAB:   state_next = S_DUMMY;
                            default: state_next = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (byte_done && addr_bytes_reg == 2'd2) begin
                        state_next = S_DATA;
                        mem_issue  = 1'b1;
                    end
                end
                S_DATA: begin
                    // Prefetch the next byte as soon as the current one has been clocked out.
                    if (byte_done) mem_issue = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Byte presented at the first fall after a byte boundary; zero means "no output byte".
    always_comb begin
        load_byte = 8'h00;
        case (state_reg)
            S_DATA: load_byte = hold_reg;
            S_ID: begin
                case (id_idx_reg)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    2'd2:    load_byte = JEDEC_ID[7:0];
                    default: load_byte = 8'h00;
                endcase
            end
            S_DUMMY: begin
                if (dummy_cnt_reg == 2'd0) load_byte = DEVICE_ID;
            end
            default: ;
        endcase
    end

    always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
        if (io_asyncReset) begin
            sclk_meta_reg      <= 1'b0;
            sclk_sync_reg      <= 1'b0;
            sclk_prev_reg      <= 1'b0;
            cs_meta_reg        <= 1'b0;
            cs_sync_reg        <= 1'b0;
            cs_prev_reg        <= 1'b0;
            mosi_meta_reg      <= 1'b0;
            mosi_sync_reg      <= 1'b0;
            bit_cnt_reg        <= 3'd0;
            rx_reg             <= 8'h00;
            tx_reg             <= 8'h00;
            hold_reg           <= 8'h00;
            addr_acc_reg       <= '0;
            addr_bytes_reg     <= 2'd0;
            id_idx_reg         <= 2'd0;
            dummy_cnt_reg      <= 2'd0;
            rsp_pending_reg    <= 1'b0;
            io_spi_miso        <= 1'b0;
            io_mem_cmd_valid   <= 1'b0;
            io_mem_cmd_address <= '0;
            io_selected        <= 1'b0;
            io_lastCommand     <= 8'h00;
        end else begin
            sclk_meta_reg <= io_spi_sclk;
            sclk_sync_reg <= sclk_meta_reg;
            sclk_prev_reg <= sclk_sync_reg;
            // cs synchronizer clears to "selected" so a cs_n held low through reset never looks like a fresh fall.
            cs_meta_reg   <= io_spi_cs_n;
            cs_sync_reg   <= cs_meta_reg;
            cs_prev_reg   <= cs_sync_reg;
            mosi_meta_reg <= io_spi_mosi;
            mosi_sync_reg <= mosi_meta_reg;
            io_selected   <= ~cs_sync_reg;

            if (state_reg == S_IDLE || cs_sync_reg) begin
                bit_cnt_reg      <= 3'd0;
                rx_reg           <= 8'h00;
                tx_reg           <= 8'h00;
                addr_acc_reg     <= '0;
                addr_bytes_reg   <= 2'd0;
                id_idx_reg       <= 2'd0;
                dummy_cnt_reg    <= 2'd0;
                rsp_pending_reg  <= 1'b0;
                io_spi_miso      <= 1'b0;
                io_mem_cmd_valid <= 1'b0;
            end else begin
                io_mem_cmd_valid <= mem_issue;
                rsp_pending_reg  <= io_mem_cmd_valid;
                if (rsp_pending_reg) hold_reg <= io_mem_rsp_data;

                if (rise) begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    rx_reg      <= rx_next;
                    if (state_reg == S_ADDR) begin
                        addr_acc_reg <= addr_acc_next;
                        if (byte_done) addr_bytes_reg <= addr_bytes_reg + 2'd1;
                    end
                    if (byte_done && state_reg == S_CMD) begin
                        io_lastCommand <= rx_next;
                        dummy_cnt_reg  <= 2'd3;
                        id_idx_reg     <= 2'd0;
                    end
                    if (byte_done && state_reg == S_DUMMY && dummy_cnt_reg != 2'd0) begin
                        dummy_cnt_reg <= dummy_cnt_reg - 2'd1;
                    end
                end

                if (mem_issue) begin
                    io_mem_cmd_address <= (state_reg == S_ADDR) ? addr_acc_next
                                                                : io_mem_cmd_address + ADDR_WIDTH'(1);
                end

                if (fall) begin
                    if (bit_cnt_reg == 3'd0) begin
                        io_spi_miso <= load_byte[7];
                        tx_reg      <= {load_byte[6:0], 1'b0};
                        if (state_reg == S_ID && id_idx_reg != 2'd3) id_idx_reg <= id_idx_reg + 2'd1;
                    end else begin
                        io_spi_miso <= tx_reg[7];
                        tx_reg      <= {tx_reg[6:0], 1'b0};
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: directed flash scenarios plus randomized transactions
// checked against a byte-level model of the flash command set.
module tb_spi_flash_responder;
    localparam int AW   = 16;
    localparam int HALF = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sclk = 1'b0;
    logic          cs_n = 1'b1;
    logic          mosi = 1'b0;
    logic          miso;
    logic          cmd_valid;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    rsp_data = 8'h00;
    logic          selected;
    logic [7:0]    last_cmd;

    always #5 clk = ~clk;

    spi_flash_responder #(.ADDR_WIDTH(AW)) dut (
        .io_mainClk        (clk),
        .io_asyncReset     (rst),
        .io_spi_sclk       (sclk),
        .io_spi_cs_n       (cs_n),
        .io_spi_mosi       (mosi),
        .io_spi_miso       (miso),
        .io_mem_cmd_valid  (cmd_valid),
        .io_mem_cmd_address(cmd_addr),
        .io_mem_rsp_data   (rsp_data),
        .io_selected       (selected),
        .io_lastCommand    (last_cmd)
    );

    logic [7:0]    mem [0:65535];
    logic [AW-1:0] addr_log [$];
    logic          prev_valid = 1'b0;
    bit            hold_rsp = 1'b0;
    int            checks_total  = 0;
    int            checks_passed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Memory: data for a strobe is stable through the following cycle, garbage otherwise.
    always @(negedge clk) begin
        if (cmd_valid) begin
            check_eq("cmd_gap", {31'b0, prev_valid}, 32'h0);
            addr_log.push_back(cmd_addr);
            rsp_data = mem[cmd_addr];
            hold_rsp = 1'b1;
        end else if (hold_rsp) begin
            hold_rsp = 1'b0;
        end else begin
            rsp_data = 8'($urandom);
        end
        prev_valid = cmd_valid;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        wait_clks(HALF);
        r = miso;
        sclk = 1'b1;
        wait_clks(HALF);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] t, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(t[i], b);
            r[i] = b;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_end();
        wait_clks(HALF);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clks(2 * HALF);
    endtask

    // Expected byte i of the response phase, straight from the command definitions.
    function automatic logic [7:0] model_byte(input logic [7:0] op, input logic [23:0] addr, input int i);
        logic [15:0] a;
        logic [23:0] id;
        id = 24'hEF4018;
        case (op)
            8'h03: begin
                a = addr[15:0] + 16'(i);
                return mem[a];
            end
            8'h9F:   return (i < 3) ? id[23 - 8 * i -: 8] : 8'h00;
            8'hAB:   return 8'h17;
            default: return 8'h00;
        endcase
    endfunction

    task automatic run_txn(input string tag, input logic [7:0] op, input logic [23:0] addr, input int n);
        logic [7:0]    r;
        logic [7:0]    tx;
        logic [15:0]   ea;
        int            exp_cmds;
        addr_log.delete();
        cs_begin();
        spi_byte(op, r);
        check_eq($sformatf("%s_op_miso", tag), r, 8'h00);
        if (op == 8'h03) begin
            for (int k = 0; k < 3; k++) begin
                tx = addr[23 - 8 * k -: 8];
                spi_byte(tx, r);
                check_eq($sformatf("%s_addr%0d_miso", tag, k), r, 8'h00);
            end
        end
        if (op == 8'hAB) begin
            for (int k = 0; k < 3; k++) begin
                spi_byte(8'($urandom), r);
                check_eq($sformatf("%s_dummy%0d_miso", tag, k), r, 8'h00);
            end
        end
        for (int i = 0; i < n; i++) begin
            spi_byte(8'($urandom), r);
            check_eq($sformatf("%s_data%0d", tag, i), r, model_byte(op, addr, i));
        end
        check_eq($sformatf("%s_selected", tag), selected, 1'b1);
        cs_end();
        check_eq($sformatf("%s_lastcmd", tag), last_cmd, op);
        check_eq($sformatf("%s_deselected", tag), selected, 1'b0);
        exp_cmds = (op == 8'h03) ? n + 1 : 0;
        check_eq($sformatf("%s_cmd_count", tag), addr_log.size(), exp_cmds);
        if (op == 8'h03) begin
            for (int i = 0; i < addr_log.size() && i < exp_cmds; i++) begin
                ea = addr[15:0] + 16'(i);
                check_eq($sformatf("%s_cmd_addr%0d", tag, i), addr_log[i], ea);
            end
        end
        $display("txn %-8s op=%02h addr=%06h bytes=%0d mem_cmds=%0d", tag, op, addr, n, addr_log.size());
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  r;
        logic        b;
        logic [7:0]  op;
        logic [7:0]  exp_byte;
        logic [23:0] ra;

        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);

        wait_clks(4);
        rst = 1'b0;
        wait_clks(6);
        check_eq("rst_miso", miso, 1'b0);
        check_eq("rst_valid", cmd_valid, 1'b0);
        check_eq("rst_addr", cmd_addr, 16'h0000);
        check_eq("rst_selected", selected, 1'b0);
        check_eq("rst_lastcmd", last_cmd, 8'h00);
        $display("txn reset   outputs idle");

        run_txn("read10", 8'h03, 24'h000010, 4);
        run_txn("readwrap", 8'h03, 24'h00FFFE, 4);
        run_txn("jedec", 8'h9F, 24'h0, 5);
        run_txn("status", 8'h05, 24'h0, 2);
        run_txn("devid", 8'hAB, 24'h0, 2);

        // Abort a READ after 13 address bits.
        addr_log.delete();
        cs_begin();
        spi_byte(8'h03, r);
        for (int i = 0; i < 13; i++) spi_bit(1'($urandom), b);
        cs_end();
        check_eq("abort_cmd_count", addr_log.size(), 0);
        $display("txn abort   op=03 13 address bits, mem_cmds=%0d", addr_log.size());
        run_txn("read20", 8'h03, 24'h000020, 1);

        run_txn("op02", 8'h02, 24'h0, 4);

        // Reset while the second data byte is being presented.
        addr_log.delete();
        cs_begin();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        spi_byte(8'h7F, r);
        spi_byte(8'h00, r);
        check_eq("prerst_data0", r, model_byte(8'h03, 24'h00007F, 0));
        wait_clks(6);
        exp_byte = model_byte(8'h03, 24'h00007F, 1);
        check_eq("prerst_miso", miso, exp_byte[7]);
        check_eq("prerst_addr", cmd_addr, 16'h0080);
        rst = 1'b1;
        #1;
        check_eq("midrst_miso", miso, 1'b0);
        check_eq("midrst_valid", cmd_valid, 1'b0);
        check_eq("midrst_addr", cmd_addr, 16'h0000);
        check_eq("midrst_selected", selected, 1'b0);
        check_eq("midrst_lastcmd", last_cmd, 8'h00);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(4);
        addr_log.delete();
        spi_byte(8'h9F, r);
        spi_byte(8'h00, r);
        check_eq("postrst_idle_miso", r, 8'h00);
        check_eq("postrst_idle_lastcmd", last_cmd, 8'h00);
        cs_end();
        check_eq("postrst_idle_cmds", addr_log.size(), 0);
        $display("txn rstmid  reset during data byte, stayed idle until fresh select");
        run_txn("read05", 8'h03, 24'h000005, 2);

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 4))
                0: op = 8'h03;
                1: op = 8'h9F;
                2: op = 8'h05;
                3: op = 8'hAB;
                default: begin
                    op = 8'($urandom);
                    while (op == 8'h03 || op == 8'h9F || op == 8'h05 || op == 8'hAB) op = 8'($urandom);
                end
            endcase
            ra = 24'($urandom);
            run_txn($sformatf("rnd%0d", t), op, ra, int'($urandom_range(1, 4)));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
